div_core: RTL and testbench

//  Multicycle 32-bit signed integer divider for the multicycle processor datapath.

---
 rtl/div_core_if.sv | 16 +
 rtl/div_core.sv | 120 ++++++++++++
 tb/tb_div_core.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/div_core_if.sv
// Handshake and operand/result bundle between the control unit and the divider.
interface div_core_if;
    localparam int unsigned W = 32;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         dbz;
    logic [W-1:0] val;
    logic [W-1:0] rem;

    modport master (output start, a, b, input busy, done, dbz, val, rem);
    modport slave  (input start, a, b, output busy, done, dbz, val, rem);
endinterface

// File: rtl/div_core.sv
// Multicycle 32-bit signed divider: restoring radix-2, one quotient bit per cycle,
// with sign correction and divide-by-zero reporting.
module div_core (
    input logic        clk,
    input logic        rst,
    div_core_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  quo, quo_nx;
    logic [W-1:0]  pr, pr_nx;
    logic [W-1:0]  b_abs, b_abs_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          neg_q, neg_q_nx;
    logic          neg_r, neg_r_nx;
    logic          zdiv, zdiv_nx;
    logic          busy_nx, done_nx, dbz_nx;
    logic [W-1:0]  val_nx, rem_nx;
    logic [W:0]    shifted, trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            quo      <= '0;
            pr       <= '0;
            b_abs    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zdiv     <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dbz  <= 1'b0;
            bus.val  <= '0;
            bus.rem  <= '0;
        end else begin
            state    <= state_nx;
            quo      <= quo_nx;
            pr       <= pr_nx;
            b_abs    <= b_abs_nx;
            cnt      <= cnt_nx;
            neg_q    <= neg_q_nx;
            neg_r    <= neg_r_nx;
            zdiv     <= zdiv_nx;
            bus.busy <= busy_nx;
            bus.done <= done_nx;
            bus.dbz  <= dbz_nx;
            bus.val  <= val_nx;
            bus.rem  <= rem_nx;
        end
    end

    always_comb begin
        state_nx = state;
        quo_nx   = quo;
        pr_nx    = pr;
        b_abs_nx = b_abs;
        cnt_nx   = cnt;
        neg_q_nx = neg_q;
        neg_r_nx = neg_r;
        zdiv_nx  = zdiv;
        done_nx  = 1'b0;
        dbz_nx   = bus.dbz;
        val_nx   = bus.val;
        rem_nx   = bus.rem;
        // 33-bit trial subtract keeps |b| = 2^31 exact
        shifted  = {pr, quo[W-1]};
        trial    = shifted - {1'b0, b_abs};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        // quo carries the raw dividend through to FIN for rem
                        zdiv_nx  = 1'b1;
                        quo_nx   = bus.a;
                        state_nx = FIN;
                    end else begin
                        zdiv_nx  = 1'b0;
                        quo_nx   = bus.a[W-1] ? W'(~bus.a + W'(1)) : bus.a;
                        b_abs_nx = bus.b[W-1] ? W'(~bus.b + W'(1)) : bus.b;
                        neg_q_nx = bus.a[W-1] ^ bus.b[W-1];
                        neg_r_nx = bus.a[W-1];
                        pr_nx    = '0;
                        cnt_nx   = '0;
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                pr_nx  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
                quo_nx = {quo[W-2:0], ~trial[W]};
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
                if (zdiv) begin
                    dbz_nx = 1'b1;
                    val_nx = '0;
                    rem_nx = quo;
                end else begin
                    dbz_nx = 1'b0;
                    val_nx = neg_q ? W'(~quo + W'(1)) : quo;
                    rem_nx = neg_r ? W'(~pr + W'(1)) : pr;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == CALC);
    end
endmodule

// File: tb/tb_div_core.sv
// Self-checking bench for div_core: directed vector table plus reset, hold and
// continuous-start sequences.
module tb_div_core;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_core_if dif ();

    div_core dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        logic [31:0] rem;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance edge by edge until done is seen; returns edges waited.
    task automatic wait_done(input int limit, output int lat, output bit got);
        lat = 0;
        got = 0;
        while (!got && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            if (dif.done) got = 1;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat, output bit got);
        @(negedge clk);
        dif.a     = a;
        dif.b     = b;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        wait_done(60, lat, got);
    endtask

    initial begin
        int lat;
        bit got;
        int signed sa, sb;
        logic [31:0] ev, er;

        checks   = 0;
        failures = 0;

        vecs[0] = '{32'd1000,       32'd7,          32'd142,        32'd6,         1'b0, 33};
        vecs[1] = '{32'd9000,       -32'sd4,        -32'sd2250,     32'd0,         1'b0, 33};
        vecs[2] = '{32'd1000,       -32'sd3,        -32'sd333,      32'd1,         1'b0, 33};
        vecs[3] = '{-32'sd1000,     32'd7,          -32'sd142,      -32'sd6,       1'b0, 33};
        vecs[4] = '{-32'sd7,        -32'sd2,        32'd3,          -32'sd1,       1'b0, 33};
        vecs[5] = '{32'd5000,       32'd0,          32'd0,          32'd5000,      1'b1, 1};
        vecs[6] = '{32'd5000,       32'd3,          32'd1666,       32'd2,         1'b0, 33};
        vecs[7] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,         1'b0, 33};
        vecs[8] = '{32'd7,          32'h8000_0000,  32'd0,          32'd7,         1'b0, 33};

        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_val",  dif.val,  32'd0);
        chk("reset_rem",  dif.rem,  32'd0);
        chk("reset_done", 32'(dif.done), 32'd0);
        chk("reset_busy", 32'(dif.busy), 32'd0);
        chk("reset_dbz",  32'(dif.dbz),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, got);
            chk($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_val", i), dif.val, vecs[i].val);
            chk($sformatf("v%0d_rem", i), dif.rem, vecs[i].rem);
            chk($sformatf("v%0d_dbz", i), 32'(dif.dbz), 32'(vecs[i].dbz));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(dif.done), 32'd0);
        end

        // Results hold through a running operation; operand changes are ignored.
        @(negedge clk);
        dif.a     = 32'd100;
        dif.b     = 32'd9;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.a     = 32'd55;
        dif.b     = 32'd0;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_busy", 32'(dif.busy), 32'd1);
        chk("hold_val",  dif.val, 32'd0);
        chk("hold_rem",  dif.rem, 32'd7);
        wait_done(40, lat, got);
        chk("hold_done_seen", 32'(got), 32'd1);
        chk("hold_new_val", dif.val, 32'd11);
        chk("hold_new_rem", dif.rem, 32'd1);

        // Reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        dif.a     = 32'd1000;
        dif.b     = 32'd7;
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_val",  dif.val, 32'd0);
        chk("rst_mid_rem",  dif.rem, 32'd0);
        chk("rst_mid_busy", 32'(dif.busy), 32'd0);
        chk("rst_mid_dbz",  32'(dif.dbz),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(40, lat, got);
        chk("rst_mid_no_done", 32'(got), 32'd0);

        // start held high; a new operand pair is applied right after a done pulse.
        @(negedge clk);
        dif.a     = 32'd1000;
        dif.b     = 32'd7;
        dif.start = 1'b1;
        for (int j = 0; j < 9; j++) begin
            sa = 1000 * (j + 1);
            sb = 7 - j;
            wait_done(60, lat, got);
            chk($sformatf("held%0d_done_seen", j), 32'(got), 32'd1);
            if (sb == 0) begin
                ev = 32'd0;
                er = sa;
            end else begin
                ev = sa / sb;
                er = sa % sb;
            end
            chk($sformatf("held%0d_val", j), dif.val, ev);
            chk($sformatf("held%0d_rem", j), dif.rem, er);
            chk($sformatf("held%0d_dbz", j), 32'(dif.dbz), (sb == 0) ? 32'd1 : 32'd0);
            if (j < 8) begin
                repeat (100) @(posedge clk);
                wait_done(60, lat, got);
                chk($sformatf("held%0d_repeat_seen", j), 32'(got), 32'd1);
                dif.a = 32'(1000 * (j + 2));
                dif.b = 32'(6 - j);
            end
        end
        dif.start = 1'b0;
        repeat (40) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
